// File: rtl/tiny16_dbg_pkg.sv
// rtl/tiny16_dbg_pkg.sv - command codes, loader state encoding and word-size helper
package tiny16_dbg_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A0,
    ST_A1,
    ST_C0,
    ST_C1,
    ST_DATA,
    ST_WRITE
  } state_t;

  // Bytes per memory word.
  function automatic int wb_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/tiny16_word_pack.sv
// rtl/tiny16_word_pack.sv - assembles LSB-first bytes into one memory word
module tiny16_word_pack
  import tiny16_dbg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        din,
  output logic [DATA_W-1:0] word_next,
  output logic              last
);

  localparam int WB = wb_of(DATA_W);
  localparam int CW = (WB > 1) ? $clog2(WB) : 1;

  logic [DATA_W-1:0] word_q;
  logic [CW-1:0]     bcnt;

  // Bytes enter at the top and move down, so the first byte ends in the LSB lane.
  generate
    if (WB == 1) begin : g_one
      assign word_next = din;
    end else begin : g_multi
      assign word_next = {din, word_q[DATA_W-1:8]};
    end
  endgenerate

  assign last = (bcnt == CW'(WB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      bcnt   <= '0;
    end else if (clr) begin
      word_q <= '0;
      bcnt   <= '0;
    end else if (shift) begin
      word_q <= word_next;
      bcnt   <= last ? '0 : bcnt + 1'b1;
    end
  end

endmodule

// File: rtl/tiny16_loader.sv
// rtl/tiny16_loader.sv - byte-stream program loader and run/halt/step control for tiny16
module tiny16_loader
  import tiny16_dbg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_en,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [15:0]       addr;
  logic [15:0]       remaining;
  logic [7:0]        cnt_lo;
  logic              running;
  logic              accept;
  logic              shift;
  logic              last;
  logic              load_start;
  logic [DATA_W-1:0] word_next;

  assign accept     = in_valid & in_ready;
  assign shift      = accept && (state == ST_DATA);
  assign load_start = accept && (state == ST_IDLE) && (in_data == CMD_LOAD);

  tiny16_word_pack #(.DATA_W(DATA_W)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (load_start),
    .shift     (shift),
    .din       (in_data),
    .word_next (word_next),
    .last      (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      cpu_en    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      cnt_lo    <= '0;
      running   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // Free-running enable follows RUN mode; a STEP overrides it for one cycle.
      cpu_en <= running;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err <= 1'b0;
            case (in_data)
              CMD_LOAD: begin
                state    <= ST_A0;
                busy     <= 1'b1;
                cpu_hold <= 1'b1;
                cpu_en   <= 1'b0;
                running  <= 1'b0;
              end
              CMD_RUN: begin
                cpu_hold <= 1'b0;
                cpu_en   <= 1'b1;
                running  <= 1'b1;
              end
              CMD_STEP: begin
                cpu_hold <= 1'b0;
                cpu_en   <= 1'b1;
                running  <= 1'b0;
              end
              CMD_HALT: begin
                cpu_en  <= 1'b0;
                running <= 1'b0;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        ST_A0: begin
          if (accept) begin
            addr[7:0] <= in_data;
            state     <= ST_A1;
          end
        end
        ST_A1: begin
          if (accept) begin
            addr[15:8] <= in_data;
            state      <= ST_C0;
          end
        end
        ST_C0: begin
          if (accept) begin
            cnt_lo <= in_data;
            state  <= ST_C1;
          end
        end
        ST_C1: begin
          if (accept) begin
            if ({in_data, cnt_lo} == 16'd0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              remaining <= {in_data, cnt_lo};
              state     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Write is issued from the edge that takes the final byte of the word.
          if (shift && last) begin
            state     <= ST_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= addr[ADDR_W-1:0];
            mem_wdata <= word_next;
            addr      <= addr + 16'd1;
            remaining <= remaining - 16'd1;
          end
        end
        ST_WRITE: begin
          in_ready <= 1'b1;
          if (remaining == 16'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_DATA;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tiny16_loader.md
# tiny16_loader

Debug and program-load controller for the tiny16 core. It accepts a byte-wide command stream with a valid/ready handshake and assembles bytes into DATA_W-bit words. It writes those words into the unified program/data memory, then controls the core with a hold (reset) line and a clock enable. This supports run, halt and single-step operation in hardware. It sits between the host byte link (UART receiver) and the `tiny16` core/memory, replacing direct memory preloading as the way programs enter the design.

## Interface
- ADDR_W, 16, memory word-address width (1..16); addresses wrap modulo 2^ADDR_W
- DATA_W, 16, memory word width; must be a multiple of 8 (WB = DATA_W/8 bytes per word)
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- in_data  in  8  command/data byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted on an edge where in_valid & in_ready
- mem_we  out  1  memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  DATA_W  write data
- cpu_hold  out  1  drives core RST; 1 = core held in reset
- cpu_en  out  1  core clock enable
- busy  out  1  1 while a LOAD frame is in progress
- err  out  1  sticky unknown-command flag

## Operation
- Commands are single bytes accepted in IDLE: 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 HALT.
- LOAD frame layout: cmd, addr_lo, addr_hi, cnt_lo, cnt_hi, then cnt×WB data bytes. All fields are LSB first. Address bits above ADDR_W are ignored. cnt is in words.
- States: IDLE → A0 → A1 → C0 → C1 → DATA ↔ WRITE → IDLE.
- At C1 accept: cnt==0 goes to IDLE with no write; otherwise DATA.
- DATA shifts bytes into the word, filling from the LSB byte up. After byte WB is accepted → WRITE.
- WRITE lasts one cycle: mem_we=1, in_ready=0, address increments (wrapping), remaining count decrements. Then DATA, or IDLE if the count reaches 0.
- LOAD accept sets cpu_hold=1 and cpu_en=0. Both stay that way after the frame ends, until RUN or STEP.
- RUN: cpu_hold=0, cpu_en=1 continuously.
- STEP: cpu_hold=0; cpu_en=1 for exactly one cycle, then 0.
- HALT: cpu_en=0; cpu_hold unchanged (core state preserved).
- A byte equal to a command code inside a LOAD frame is data, never a command.
- Unknown byte in IDLE: err=1, state stays IDLE. err clears on the next valid command accept or on RST.
- busy=1 from the LOAD accept through the final WRITE cycle.
- in_ready=1 in every state except WRITE.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_en=0, busy=0, err=0, state IDLE.
- All outputs are registered.
- Word latency: the last byte of a word is accepted at edge N. mem_we/addr/wdata are valid in the cycle after N; the next byte can be accepted at edge N+2.
- Throughput: one word per WB+1 cycles with in_valid held high.
- RUN/STEP/HALT take effect in the cycle after their accept edge. The STEP pulse is in the cycle after accept.
- A second STEP accepted while a pulse is active produces one additional pulse in the following cycle. Pulses are never merged.
- RST asserted mid-frame: partial word discarded, no write issued, core re-held, all outputs to reset values immediately (asynchronous).

## Structure
- Package `tiny16_dbg_pkg` holds the command byte constants, the state enum, and the WB derivation function.
- Sub-module `tiny16_word_pack` holds the byte shift register, byte counter, and word-complete flag, parametrised by DATA_W.
- The FSM, address/count counters, and core control stay in `tiny16_loader`.

## Test plan
- Reset then idle → cpu_hold=1, cpu_en=0, in_ready=1, no mem_we.
- Load four words at address 0:
  - Stream 01 00 00 04 00 01 15 02 17 30 34 03 C0.
  - Required writes: 0x0000←1501, 0x0001←1702, 0x0002←3430, 0x0003←C003.
  - in_ready is low exactly on the 4 WRITE cycles; busy falls after the last write.
- Then RUN → cpu_hold=0 next cycle and cpu_en held high. Then STEP, STEP → after the HALT effect, exactly two single-cycle cpu_en pulses.
- Wrap (ADDR_W=4): load cnt=3 at address 0xE → writes to E, F, 0. A frame with cnt=0 returns to IDLE with no writes.
- Byte 0x7F in IDLE → err=1. A following 0x04 clears err. A data byte 0x02 inside a LOAD frame is written as data, and the core stays held.
- RST asserted after 2 of the data bytes for the first word → no mem_we. A fresh load then starts cleanly at its own address.
